// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx among NUM_REQ byte producers, round robin, self-timing each frame.
// Latency: request valid to o_data_valid/o_req_ack is 1 cycle; grants are FRAME_TOTAL+1 cycles apart at best.
// Backpressure: requesters hold valid+data until acked; requests are ignored while a frame is timed (o_busy).
// Build option: define UART_TX_ARB_PRIORITY0_EN to give requester 0 strict priority over the round robin.
// The enclosing top drives uart_tx i_rst_n from ~i_rst so both blocks reset together.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int CLK_FRE      = 50,
    parameter int BAUD_RATE    = 9600,
    parameter int PARITY_ON    = 0,
    parameter int GUARD_CYCLES = 16
) (
    input  logic                          i_clk_sys,
    input  logic                          i_rst,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_req_ack,
    output logic [DATA_WIDTH-1:0]         o_data_tx,
    output logic                          o_data_valid,
    output logic                          o_busy,
    output logic [$clog2(NUM_REQ)-1:0]    o_grant_id
);

    // uart_tx has no busy flag, so the whole frame (start, data, parity, stop)
    // plus a guard gap is timed here from the clock and baud rate.
    localparam int BIT_CYCLES  = (CLK_FRE * 1000000) / BAUD_RATE;
    localparam int FRAME_TOTAL = BIT_CYCLES * (2 + DATA_WIDTH + PARITY_ON) + GUARD_CYCLES;
    localparam int CNT_W       = $clog2(FRAME_TOTAL + 1);
    localparam int ID_W        = $clog2(NUM_REQ);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]            state;
    logic [ID_W-1:0]       rr_ptr;
    logic [CNT_W-1:0]      counter;

    logic [DATA_WIDTH-1:0] req_bytes [NUM_REQ];
    logic                  win_found;
    logic [ID_W-1:0]       win_id;
    logic                  prio_hit;
    logic [NUM_REQ-1:0]    win_onehot;
    logic [ID_W-1:0]       rr_next;
    logic [ID_W-1:0]       scan_id;
    int                    scan_idx;

    // Unpack the flat request data bus into one byte per requester.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_bytes[gi] = i_req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Pick the winner: first pending requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan_idx  = 0;
        scan_id   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = int'(rr_ptr) + i;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            scan_id = ID_W'(scan_idx);
            if (!win_found && i_req_valid[scan_id]) begin
                win_found = 1'b1;
                win_id    = scan_id;
            end
        end
`ifdef UART_TX_ARB_PRIORITY0_EN
        // Requester 0 overrides the round robin and leaves rr_ptr untouched,
        // so the others keep their relative order once it goes quiet.
        prio_hit = i_req_valid[0];
        if (prio_hit) begin
            win_found = 1'b1;
            win_id    = '0;
        end
`else
        prio_hit = 1'b0;
`endif
    end

    // One-hot ack vector and the pointer value just past the winner.
    always_comb begin
        win_onehot         = '0;
        win_onehot[win_id] = 1'b1;
        rr_next            = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : (win_id + ID_W'(1));
    end

    // Grant in IDLE, then time the frame in HOLD; ack/valid are single-cycle pulses.
    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            state        <= ST_IDLE;
            rr_ptr       <= '0;
            counter      <= '0;
            o_req_ack    <= '0;
            o_data_valid <= 1'b0;
            o_data_tx    <= '0;
            o_grant_id   <= '0;
        end else begin
            o_req_ack    <= '0;
            o_data_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (win_found) begin
                        o_req_ack    <= win_onehot;
                        o_data_valid <= 1'b1;
                        o_data_tx    <= req_bytes[win_id];
                        o_grant_id   <= win_id;
                        if (!prio_hit) begin
                            rr_ptr <= rr_next;
                        end
                        // The pulse cycle counts as the first of FRAME_TOTAL HOLD cycles.
                        counter <= CNT_W'(FRAME_TOTAL - 1);
                        state   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (counter == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        counter <= counter - CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy = (state == ST_HOLD);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios plus random traffic against a frame-level reference model.
// Latency: model expects the grant pulse one cycle after an idle-cycle request.
// Backpressure: bench requesters hold valid+data until acked and refill after a random gap.
module tb_uart_tx_arbiter;
    localparam int NR = 4;
    localparam int DW = 8;
    // 1 MHz / 250 kbaud = 4 clocks per bit; 10-bit frame plus 16 guard clocks.
    localparam int FT = 56;

    logic           clk = 1'b0;
    logic           rst;
    logic [NR-1:0]  req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]  req_ack;
    logic [DW-1:0]  data_tx;
    logic           data_valid;
    logic           busy;
    logic [1:0]     grant_id;

    int checks   = 0;
    int failures = 0;

    // Reference model: cycle index, last busy cycle, round-robin pointer, held outputs.
    int            cyc        = 0;
    int            busy_until = -1;
    int            rr         = 0;
    logic [DW-1:0] m_data     = '0;
    int            m_gid      = 0;

    int gap [NR];
    logic refill [NR];

    uart_tx_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .CLK_FRE(1), .BAUD_RATE(250000),
        .PARITY_ON(0), .GUARD_CYCLES(16)
    ) dut (
        .i_clk_sys   (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .o_req_ack   (req_ack),
        .o_data_tx   (data_tx),
        .o_data_valid(data_valid),
        .o_busy      (busy),
        .o_grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NR-1:0] v, input int ptr);
        int k;
        for (int i = 0; i < NR; i++) begin
            k = (ptr + i) % NR;
            if (v[k[1:0]]) return k;
        end
        return 0;
    endfunction

    task automatic set_req(input int k, input logic vld, input logic [DW-1:0] d);
        req_valid[k[1:0]]    = vld;
        req_data[k*DW +: DW] = d;
    endtask

    // Predict from the inputs driven this cycle, clock once, then compare every output.
    task automatic step();
        logic [NR-1:0] e_ack;
        logic          e_vld;
        logic          e_busy;
        int            g;
        e_ack  = '0;
        e_vld  = 1'b0;
        e_busy = 1'b0;
        if (rst) begin
            rr         = 0;
            busy_until = cyc;
            m_data     = '0;
            m_gid      = 0;
        end else if (cyc > busy_until && req_valid != '0) begin
            g = rr_pick(req_valid, rr);
`ifdef UART_TX_ARB_PRIORITY0_EN
            if (req_valid[0]) g = 0;
            else rr = (g + 1) % NR;
`else
            rr = (g + 1) % NR;
`endif
            e_ack[g[1:0]] = 1'b1;
            e_vld         = 1'b1;
            e_busy        = 1'b1;
            m_data        = req_data[g*DW +: DW];
            m_gid         = g;
            busy_until    = cyc + FT;
        end else begin
            e_busy = (cyc + 1 <= busy_until);
        end
        @(posedge clk);
        #1;
        cyc++;
        chk_eq("data_valid", data_valid, e_vld);
        chk_eq("req_ack", req_ack, e_ack);
        chk_eq("data_tx", data_tx, m_data);
        chk_eq("grant_id", grant_id, m_gid);
        chk_eq("busy", busy, e_busy);
    endtask

    task automatic do_reset(input int n);
        rst       = 1'b1;
        req_valid = '0;
        for (int i = 0; i < n; i++) step();
        rst = 1'b0;
    endtask

    initial begin
        int order[$];
        int pcyc[$];
        int exp2 [5];
        int exp3 [4];
        int n;
        int stray;

        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        for (int k = 0; k < NR; k++) begin
            gap[k]    = 0;
            refill[k] = 1'b0;
        end

        // Single request: pulse one cycle later, busy exactly FT cycles.
        do_reset(3);
        for (int i = 0; i < 6; i++) step();
        set_req(2, 1'b1, 8'h41);
        step();
        chk_eq("s1_pulse", data_valid, 1'b1);
        req_valid = '0;
        n = 1;
        for (int t = 0; t < 200 && busy; t++) begin
            step();
            if (busy) n++;
        end
        chk_eq("s1_busy_len", n, FT);

        // All requesters at once, each refilling the cycle after its ack.
        do_reset(1);
        for (int k = 0; k < NR; k++) set_req(k, 1'b1, 8'hA0 + DW'(k));
        order.delete();
        pcyc.delete();
        for (int t = 0; t < 400 && order.size() < 5; t++) begin
            for (int k = 0; k < NR; k++) begin
                if (refill[k]) begin
                    set_req(k, 1'b1, 8'hB0 + DW'(t[3:0]));
                    refill[k] = 1'b0;
                end
            end
            step();
            for (int k = 0; k < NR; k++) begin
                if (req_ack[k[1:0]]) begin
                    order.push_back(k);
                    pcyc.push_back(cyc);
                    req_valid[k[1:0]] = 1'b0;
                    refill[k] = 1'b1;
                end
            end
        end
`ifdef UART_TX_ARB_PRIORITY0_EN
        exp2 = '{0, 0, 0, 0, 0};
`else
        exp2 = '{0, 1, 2, 3, 0};
`endif
        chk_eq("s2_grant_count", order.size(), 5);
        for (int i = 0; i < order.size() && i < 5; i++) chk_eq("s2_order", order[i], exp2[i]);
        for (int i = 1; i < pcyc.size(); i++) chk_eq("s2_spacing", pcyc[i] - pcyc[i-1], FT + 1);
        for (int k = 0; k < NR; k++) refill[k] = 1'b0;

        // Requesters 1 and 3 held continuously: strict alternation.
        do_reset(1);
        set_req(1, 1'b1, 8'h11);
        set_req(3, 1'b1, 8'h33);
        order.delete();
        stray = 0;
        for (int t = 0; t < 400 && order.size() < 4; t++) begin
            step();
            if (req_ack[0] || req_ack[2]) stray++;
            if (req_ack[1]) order.push_back(1);
            if (req_ack[3]) order.push_back(3);
        end
        req_valid = '0;
        exp3 = '{1, 3, 1, 3};
        chk_eq("s3_grant_count", order.size(), 4);
        for (int i = 0; i < order.size() && i < 4; i++) chk_eq("s3_order", order[i], exp3[i]);
        chk_eq("s3_stray_acks", stray, 0);

        // Wrap: last grant was 3, so 0 beats 3 next.
        for (int t = 0; t < 100 && busy; t++) step();
        set_req(0, 1'b1, 8'h10);
        set_req(3, 1'b1, 8'h13);
        n = 0;
        for (int t = 0; t < 10 && !data_valid; t++) step();
        chk_eq("s4_first_pulse", data_valid, 1'b1);
        chk_eq("s4_first_id", grant_id, 0);
        req_valid[0] = 1'b0;
        for (int t = 0; t < 100 && !(data_valid && !req_ack[0]); t++) step();
        chk_eq("s4_second_id", grant_id, 3);
        req_valid = '0;

        // Reset mid-frame abandons the timer; pending request 1 wins right after.
        do_reset(1);
        set_req(2, 1'b1, 8'h5A);
        for (int t = 0; t < 10 && !data_valid; t++) step();
        req_valid = '0;
        for (int i = 0; i < 35; i++) step();
        set_req(1, 1'b1, 8'h77);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_eq("s5_busy_after_rst", busy, 1'b0);
        chk_eq("s5_data_after_rst", data_tx, 8'h00);
        chk_eq("s5_ack_after_rst", req_ack, 4'b0000);
        step();
        chk_eq("s5_regrant_ack", req_ack, 4'b0010);
        chk_eq("s5_regrant_data", data_tx, 8'h77);
        req_valid = '0;

        // Random traffic: random refill gaps, occasional legal withdrawal.
        do_reset(2);
        for (int k = 0; k < NR; k++) gap[k] = $urandom_range(0, 20);
        for (int t = 0; t < 3000; t++) begin
            for (int k = 0; k < NR; k++) begin
                if (!req_valid[k[1:0]]) begin
                    if (gap[k] > 0) gap[k]--;
                    else set_req(k, 1'b1, DW'($urandom));
                end else if ($urandom_range(0, 299) == 0) begin
                    req_valid[k[1:0]] = 1'b0;
                    gap[k] = $urandom_range(0, 60);
                end
            end
            step();
            for (int k = 0; k < NR; k++) begin
                if (req_ack[k[1:0]]) begin
                    req_valid[k[1:0]] = 1'b0;
                    gap[k] = $urandom_range(0, 80);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
